// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Snapshots four digit codes per frame and scans them with a blanking gap per slot.
module seg7_scan_driver #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] digits,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_en,
  output logic [4:0]  digit_code,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      slot_q, slot_d;
  logic            first_q, first_d;
  logic [19:0]     digits_snap_q, digits_snap_d;
  logic [3:0]      en_snap_q, en_snap_d;
  logic [3:0]      dp_snap_q, dp_snap_d;
  logic [4:0]      digit_code_q, digit_code_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            dp_n_q, dp_n_d;
  logic [3:0]      an_n_q, an_n_d;
  logic            frame_start_q, frame_start_d;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      timer_q       <= '0;
      slot_q        <= 2'd0;
      first_q       <= 1'b1;
      digits_snap_q <= '0;
      en_snap_q     <= '0;
      dp_snap_q     <= '0;
      digit_code_q  <= '0;
      seg_n_q       <= 7'h7F;
      dp_n_q        <= 1'b1;
      an_n_q        <= 4'hF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      slot_q        <= slot_d;
      first_q       <= first_d;
      digits_snap_q <= digits_snap_d;
      en_snap_q     <= en_snap_d;
      dp_snap_q     <= dp_snap_d;
      digit_code_q  <= digit_code_d;
      seg_n_q       <= seg_n_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Next-state, snapshot and output logic
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TW'(1);
    slot_d        = slot_q;
    first_d       = 1'b0;
    digits_snap_d = digits_snap_q;
    en_snap_d     = en_snap_q;
    dp_snap_d     = dp_snap_q;
    frame_start_d = 1'b0;
    digit_code_d  = '0;
    an_n_d        = 4'hF;
    seg_n_d       = 7'h7F;
    dp_n_d        = 1'b1;

    // First cycle out of reset only takes the snapshot; the blank phase starts after it
    if (first_q) begin
      timer_d       = '0;
      frame_start_d = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (timer_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            timer_d = '0;
          end
        end
        ST_SHOW: begin
          if (timer_q == DWELL_LAST) begin
            state_d       = ST_BLANK;
            timer_d       = '0;
            slot_d        = slot_q + 2'd1;
            frame_start_d = (slot_q == 2'd3);
          end
        end
        default: begin
          state_d = ST_BLANK;
          timer_d = '0;
        end
      endcase
    end

    if (frame_start_d) begin
      digits_snap_d = digits;
      en_snap_d     = digit_en;
      dp_snap_d     = dp_en;
    end

    // Code presented from the start of BLANK so the external decoder settles before SHOW
    case (slot_d)
      2'd0:    digit_code_d = digits_snap_d[4:0];
      2'd1:    digit_code_d = digits_snap_d[9:5];
      2'd2:    digit_code_d = digits_snap_d[14:10];
      default: digit_code_d = digits_snap_d[19:15];
    endcase

    if ((state_d == ST_SHOW) && en_snap_d[slot_d]) begin
      an_n_d  = ~(4'b0001 << slot_d);
      seg_n_d = seg_in;
      dp_n_d  = ~dp_snap_d[slot_d];
    end
  end

  assign digit_code  = digit_code_q;
  assign seg_n       = seg_n_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule
